// File: rtl/feed_encoder.sv
// feed_encoder: frames 128-bit messages into 64-bit Avalon-ST packets
// (one header beat, then hi/lo beats per message) with sequence and drop counters.
module feed_encoder #(
    parameter int          C_PKT_DATA_WIDTH = 64,
    parameter int          C_MSG_WIDTH      = 128,
    parameter logic [31:0] SEQ_INIT         = 32'h0000_0001
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        msg_valid,
    output logic                        msg_ready,
    input  logic                        msg_sop,
    input  logic [7:0]                  msg_cnt,
    input  logic [C_MSG_WIDTH-1:0]      msg_data,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic                        out_startofpacket,
    output logic                        out_endofpacket,
    output logic [C_PKT_DATA_WIDTH-1:0] out_data,
    output logic [5:0]                  out_empty,
    output logic                        out_error,
    output logic [31:0]                 seq_num,
    output logic [15:0]                 drop_cnt
);
    typedef enum logic [2:0] {IDLE, HDR, MSG_HI, MSG_LO, WAIT} state_t;
    state_t                 state_q, state_d;
    logic [C_MSG_WIDTH-1:0] msg_buf_q, msg_buf_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [7:0]             remain_q, remain_d;
    logic                   err_q, err_d;
    logic [31:0]            seq_q, seq_d;
    logic [15:0]            drop_q, drop_d;
    logic                   last;

    assign last = remain_q == 8'd1;

    always_comb begin
        state_d   = state_q;
        msg_buf_d = msg_buf_q;
        cnt_d     = cnt_q;
        remain_d  = remain_q;
        err_d     = err_q;
        seq_d     = seq_q;
        drop_d    = drop_q;
        case (state_q)
            IDLE: begin
                if (msg_valid && msg_sop) begin
                    msg_buf_d = msg_data;
                    cnt_d     = (msg_cnt == 8'd0) ? 8'd1 : msg_cnt;
                    remain_d  = cnt_d;
                    err_d     = 1'b0;
                    state_d   = HDR;
                end else if (msg_valid) begin
                    drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                end
            end
            HDR:    state_d = out_ready ? MSG_HI : HDR;
            MSG_HI: state_d = out_ready ? MSG_LO : MSG_HI;
            MSG_LO: begin
                if (out_ready && last) begin
                    state_d = IDLE;
                    seq_d   = seq_q + 32'd1;
                    err_d   = 1'b0;
                end else if (out_ready && msg_valid) begin
                    msg_buf_d = msg_data;
                    remain_d  = remain_q - 8'd1;
                    err_d     = err_q | msg_sop;
                    state_d   = MSG_HI;
                end else if (out_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (msg_valid) begin
                    msg_buf_d = msg_data;
                    remain_d  = remain_q - 8'd1;
                    err_d     = err_q | msg_sop;
                    state_d   = MSG_HI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            msg_buf_q <= '0;
            cnt_q     <= '0;
            remain_q  <= '0;
            err_q     <= 1'b0;
            seq_q     <= SEQ_INIT;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            msg_buf_q <= msg_buf_d;
            cnt_q     <= cnt_d;
            remain_q  <= remain_d;
            err_q     <= err_d;
            seq_q     <= seq_d;
            drop_q    <= drop_d;
        end
    end

    // Continuation acceptance in MSG_LO follows out_ready so the next hi beat follows without a gap.
    assign msg_ready = !reset && (state_q == IDLE || state_q == WAIT ||
                                  (state_q == MSG_LO && !last && out_ready));
    assign out_valid         = state_q == HDR || state_q == MSG_HI || state_q == MSG_LO;
    assign out_startofpacket = state_q == HDR;
    assign out_endofpacket   = state_q == MSG_LO && last;
    assign out_error         = out_endofpacket && err_q;
    assign out_empty         = '0;
    assign out_data = (state_q == HDR)    ? {seq_q, 8'h00, cnt_q, 16'd16} :
                      (state_q == MSG_HI) ? msg_buf_q[C_MSG_WIDTH-1 -: C_PKT_DATA_WIDTH] :
                      (state_q == MSG_LO) ? msg_buf_q[C_PKT_DATA_WIDTH-1:0] : '0;
    assign seq_num  = reset ? 32'd0 : seq_q;
    assign drop_cnt = drop_q;
endmodule

// File: tb/tb_feed_encoder.sv
// tb_feed_encoder: scoreboard bench for feed_encoder; expected beats are queued
// when messages are driven and popped by a monitor as beats are accepted.
module tb_feed_encoder;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         msg_valid = 1'b0;
    logic         msg_sop = 1'b0;
    logic [7:0]   msg_cnt = 8'd0;
    logic [127:0] msg_data = '0;
    logic         out_ready = 1'b0;
    logic         msg_ready, out_valid, out_sop, out_eop, out_error;
    logic [63:0]  out_data;
    logic [5:0]   out_empty;
    logic [31:0]  seq_num;
    logic [15:0]  drop_cnt;
    logic         d2_msg_ready, d2_valid, d2_sop, d2_eop, d2_error;
    logic [63:0]  d2_data;
    logic [5:0]   d2_empty;
    logic [31:0]  d2_seq;
    logic [15:0]  d2_drop;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit toggle_en = 1'b0;
    logic [31:0]  exp_seq = 32'd1;
    logic [127:0] mq[$];
    logic [72:0]  sbq[$];
    logic [72:0]  got, prev_beat, exp_beat;
    bit           stall_prev = 1'b0;

    feed_encoder dut (
        .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_sop(msg_sop), .msg_cnt(msg_cnt), .msg_data(msg_data), .out_ready(out_ready),
        .out_valid(out_valid), .out_startofpacket(out_sop), .out_endofpacket(out_eop),
        .out_data(out_data), .out_empty(out_empty), .out_error(out_error),
        .seq_num(seq_num), .drop_cnt(drop_cnt)
    );

    feed_encoder #(.SEQ_INIT(32'hFFFF_FFFF)) dut2 (
        .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(d2_msg_ready),
        .msg_sop(msg_sop), .msg_cnt(msg_cnt), .msg_data(msg_data), .out_ready(out_ready),
        .out_valid(d2_valid), .out_startofpacket(d2_sop), .out_endofpacket(d2_eop),
        .out_data(d2_data), .out_empty(d2_empty), .out_error(d2_error),
        .seq_num(d2_seq), .drop_cnt(d2_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk);
        #1 if (toggle_en) out_ready = ~out_ready;
    end

    // Beat layout: {error, eop, sop, empty[5:0], data[63:0]}
    always @(negedge clk) begin
        got = {out_error, out_eop, out_sop, out_empty, out_data};
        if (!reset) begin
            if (stall_prev) begin
                checks++;
                if (!out_valid || got !== prev_beat) begin
                    failures++;
                    $display("FAIL stall_hold t=%0t valid=%b got=%h required=%h", $time, out_valid, got, prev_beat);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected t=%0t got=%h required=none", $time, got);
                end else begin
                    exp_beat = sbq.pop_front();
                    if (got !== exp_beat) begin
                        failures++;
                        $display("FAIL beat t=%0t got=%h required=%h", $time, got, exp_beat);
                    end
                end
            end
        end
        stall_prev = !reset && out_valid && !out_ready;
        prev_beat = got;
    end

    task automatic push_pkt(input logic [7:0] c, input bit err);
        sbq.push_back({1'b0, 1'b0, 1'b1, 6'd0, exp_seq, 8'h00, c, 16'd16});
        foreach (mq[i]) begin
            sbq.push_back({1'b0, 1'b0, 1'b0, 6'd0, mq[i][127:64]});
            sbq.push_back({err && (i == mq.size() - 1), i == mq.size() - 1, 1'b0, 6'd0, mq[i][63:0]});
        end
        exp_seq = exp_seq + 32'd1;
        mq.delete();
    endtask

    task automatic send_msg(input bit sop, input logic [7:0] c, input logic [127:0] d);
        int n = 0;
        msg_valid = 1'b1;
        msg_sop = sop;
        msg_cnt = c;
        msg_data = d;
        do begin
            @(negedge clk);
            n++;
        end while (!msg_ready && n < 200);
        if (!msg_ready) begin
            checks++;
            failures++;
            $display("FAIL msg_accept_timeout t=%0t got=no_ready required=ready", $time);
        end
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        msg_sop = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d_pending required=0", sbq.size());
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, msg_ready, out_sop, out_eop, out_error, out_data, seq_num, drop_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%b/%h/%h required=all_zero", out_valid, msg_ready, out_data, seq_num);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (msg_ready !== 1'b1 || out_valid !== 1'b0 || seq_num !== 32'd1 || drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_release got=ready%b valid%b seq%h drop%h required=ready1 valid0 seq00000001 drop0000",
                     msg_ready, out_valid, seq_num, drop_cnt);
        end
        exp_seq = 32'd1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        mq = '{128'hA0A0_0001_A0A0_0002_A1A1_0003_A1A1_0004, 128'hB0B0_0001_B0B0_0002_B1B1_0003_B1B1_0004};
        push_pkt(8'd2, 1'b0);
        send_msg(1'b1, 8'd2, 128'hA0A0_0001_A0A0_0002_A1A1_0003_A1A1_0004);
        checks++;
        if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_data !== 64'h0000_0001_0002_0010) begin
            failures++;
            $display("FAIL header_latency got=v%b s%b %h required=v1 s1 0000000100020010", out_valid, out_sop, out_data);
        end
        send_msg(1'b0, 8'd0, 128'hB0B0_0001_B0B0_0002_B1B1_0003_B1B1_0004);
        wait_drain();
        checks++;
        if (seq_num !== 32'd2) begin
            failures++;
            $display("FAIL basic_seq got=%h required=00000002", seq_num);
        end
    endtask

    task automatic test_stall();
        toggle_en = 1'b1;
        mq = '{128'hA0A0_0001_A0A0_0002_A1A1_0003_A1A1_0004, 128'hB0B0_0001_B0B0_0002_B1B1_0003_B1B1_0004};
        push_pkt(8'd2, 1'b0);
        send_msg(1'b1, 8'd2, 128'hA0A0_0001_A0A0_0002_A1A1_0003_A1A1_0004);
        send_msg(1'b0, 8'd0, 128'hB0B0_0001_B0B0_0002_B1B1_0003_B1B1_0004);
        wait_drain();
        toggle_en = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        checks++;
        if (seq_num !== 32'd3) begin
            failures++;
            $display("FAIL stall_seq got=%h required=00000003", seq_num);
        end
    endtask

    task automatic test_drop();
        for (int i = 0; i < 3; i++) send_msg(1'b0, 8'd5, 128'hDEAD + 128'(i));
        checks++;
        if (drop_cnt !== 16'd3) begin
            failures++;
            $display("FAIL drop_cnt got=%0d required=3", drop_cnt);
        end
        mq = '{128'hC0C0_C0C0_C0C0_C0C0_C1C1_C1C1_C1C1_C1C1};
        push_pkt(8'd1, 1'b0);
        send_msg(1'b1, 8'd0, 128'hC0C0_C0C0_C0C0_C0C0_C1C1_C1C1_C1C1_C1C1);
        wait_drain();
        checks++;
        if (drop_cnt !== 16'd3) begin
            failures++;
            $display("FAIL drop_cnt_after_pkt got=%0d required=3", drop_cnt);
        end
    endtask

    task automatic test_error();
        mq = '{128'h1111_0000_0000_0001_1111_0000_0000_0002,
               128'h2222_0000_0000_0001_2222_0000_0000_0002,
               128'h3333_0000_0000_0001_3333_0000_0000_0002};
        push_pkt(8'd3, 1'b1);
        send_msg(1'b1, 8'd3, 128'h1111_0000_0000_0001_1111_0000_0000_0002);
        send_msg(1'b1, 8'd9, 128'h2222_0000_0000_0001_2222_0000_0000_0002);
        send_msg(1'b0, 8'd0, 128'h3333_0000_0000_0001_3333_0000_0000_0002);
        wait_drain();
        mq = '{128'h4444_0000_0000_0001_4444_0000_0000_0002};
        push_pkt(8'd1, 1'b0);
        send_msg(1'b1, 8'd1, 128'h4444_0000_0000_0001_4444_0000_0000_0002);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int t0;
        mq = '{128'h5555_0000_0000_0001_5555_0000_0000_0002, 128'h6666_0000_0000_0001_6666_0000_0000_0002};
        push_pkt(8'd2, 1'b0);
        mq = '{128'h7777_0000_0000_0001_7777_0000_0000_0002};
        push_pkt(8'd1, 1'b0);
        send_msg(1'b1, 8'd2, 128'h5555_0000_0000_0001_5555_0000_0000_0002);
        t0 = cyc;
        send_msg(1'b0, 8'd0, 128'h6666_0000_0000_0001_6666_0000_0000_0002);
        send_msg(1'b1, 8'd1, 128'h7777_0000_0000_0001_7777_0000_0000_0002);
        checks++;
        if (cyc - t0 != 6 || out_sop !== 1'b1) begin
            failures++;
            $display("FAIL b2b_header_spacing got=%0d_cycles sop%b required=6_cycles sop1", cyc - t0, out_sop);
        end
        wait_drain();
    endtask

    task automatic test_seq_wrap();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_seq = 32'd1;
        mq = '{128'h8888_0000_0000_0001_8888_0000_0000_0002};
        push_pkt(8'd1, 1'b0);
        send_msg(1'b1, 8'd1, 128'h8888_0000_0000_0001_8888_0000_0000_0002);
        checks++;
        if (d2_valid !== 1'b1 || d2_sop !== 1'b1 || d2_data !== 64'hFFFF_FFFF_0001_0010) begin
            failures++;
            $display("FAIL wrap_header got=v%b s%b %h required=v1 s1 ffffffff00010010", d2_valid, d2_sop, d2_data);
        end
        wait_drain();
        checks++;
        if (d2_seq !== 32'd0 || seq_num !== 32'd2) begin
            failures++;
            $display("FAIL wrap_seq got=%h/%h required=00000000/00000002", d2_seq, seq_num);
        end
    endtask

    task automatic test_midreset();
        out_ready = 1'b0;
        sbq.push_back({1'b0, 1'b0, 1'b1, 6'd0, exp_seq, 8'h00, 8'd4, 16'd16});
        send_msg(1'b1, 8'd4, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h9999_AAAA_BBBB_CCCC) begin
            failures++;
            $display("FAIL midreset_msg_hi got=v%b %h required=v1 9999aaaabbbbcccc", out_valid, out_data);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_eop !== 1'b0 || msg_ready !== 1'b0 || out_data !== 64'd0 || seq_num !== 32'd0) begin
            failures++;
            $display("FAIL midreset_async got=v%b e%b r%b %h %h required=all_zero", out_valid, out_eop, msg_ready, out_data, seq_num);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        exp_seq = 32'd1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (seq_num !== 32'd1 || drop_cnt !== 16'd0 || sbq.size() != 0) begin
            failures++;
            $display("FAIL midreset_release got=seq%h drop%0d pending%0d required=seq00000001 drop0 pending0",
                     seq_num, drop_cnt, sbq.size());
        end
        mq = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        push_pkt(8'd1, 1'b0);
        send_msg(1'b1, 8'd1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_drop();
        test_error();
        test_back_to_back();
        test_seq_wrap();
        test_midreset();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/feed_encoder.md
FEED_ENCODER -- requirements
Module: feed_encoder

Interface
REQ-001 Parameter C_PKT_DATA_WIDTH, default 64, output beat width; only 64 is supported.
REQ-002 Parameter C_MSG_WIDTH, default 128, message width; SHALL equal 2*C_PKT_DATA_WIDTH.
REQ-003 Parameter SEQ_INIT, default 32'h0000_0001, sequence number after reset.
REQ-004 clk  input  1  core clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 msg_valid  input  1  message offered.
REQ-007 msg_ready  output  1  message accepted when msg_valid & msg_ready.
REQ-008 msg_sop  input  1  first message of a packet.
REQ-009 msg_cnt  input  8  messages in packet, sampled only with msg_sop.
REQ-010 msg_data  input  128  message payload, [127:64] sent first.
REQ-011 out_ready  input  1  Avalon-ST sink ready, ready latency 0.
REQ-012 out_valid, out_startofpacket, out_endofpacket  output  1 each  Avalon-ST framing.
REQ-013 out_data  output  64  beat data; out_empty  output  6  always 0; out_error  output  1  packet error flag.
REQ-014 seq_num  output  32  sequence number of next packet; drop_cnt  output  16  dropped-message count.

Function
REQ-015 Packet format SHALL be: header beat, then two beats per message (hi then lo); last lo beat carries endofpacket.
REQ-016 Header out_data SHALL be {seq_num[31:0], 8'h00, cnt[7:0], 16'd16}; startofpacket=1 on header only.
REQ-017 FSM states SHALL be IDLE, HDR, MSG_HI, MSG_LO, WAIT.
REQ-018 IDLE: msg_ready=1, out_valid=0; msg_valid&msg_sop -> capture data, cnt, remain=cnt, go HDR.
REQ-019 IDLE: msg_valid & !msg_sop -> message discarded, drop_cnt +1, saturating at 16'hFFFF.
REQ-020 msg_cnt==0 SHALL be coerced to 1 (header count field and remain both 1).
REQ-021 HDR: out_valid=1, msg_ready=0; out_ready -> MSG_HI.
REQ-022 MSG_HI: out_valid=1, out_data=buf[127:64], msg_ready=0; out_ready -> MSG_LO.
REQ-023 MSG_LO with remain==1: out_data=buf[63:0], endofpacket=1, msg_ready=0; out_ready -> IDLE, seq_num +1 (wraps FFFF_FFFF -> 0), sticky error cleared.
REQ-024 MSG_LO with remain>1: msg_ready=out_ready (combinational); out_ready&msg_valid -> capture, remain-1, MSG_HI (no gap); out_ready&!msg_valid -> WAIT.
REQ-025 WAIT: out_valid=0, msg_ready=1; msg_valid -> capture, remain-1, MSG_HI.
REQ-026 Continuation message with msg_sop=1 SHALL be encoded as data, set sticky error; out_error=1 on that packet's endofpacket beat only; msg_cnt ignored.
REQ-027 While out_valid & !out_ready, out_data/sop/eop/error SHALL hold stable; out_valid SHALL not drop.
REQ-028 Latency: header valid the cycle after sop message accepted; back-to-back packets cost one IDLE cycle.
REQ-029 Sustained throughput SHALL be one message per two cycles within a packet with out_ready=1.
REQ-030 out_valid SHALL depend only on state, never combinationally on out_ready.

Reset
REQ-031 On reset assertion (any state, any cycle) all outputs SHALL go 0 asynchronously, msg_ready=0 while reset high.
REQ-032 Reset release: state IDLE, seq_num=SEQ_INIT, drop_cnt=0, sticky error=0, remain=0.
REQ-033 Mid-packet reset SHALL abandon the packet with no endofpacket; seq_num not advanced past SEQ_INIT.

Verification
REQ-034 sop msg cnt=2, data A,B, out_ready=1 -> beats: hdr {0000_0001,00,02,0010} sop, A.hi, A.lo, B.hi, B.lo eop; seq_num=2.
REQ-035 Same packet, out_ready toggling 1/0 -> identical beat sequence, outputs stable during stalls, no duplicates.
REQ-036 Three non-sop messages in IDLE then sop cnt=0 -> drop_cnt=3, header count=1, one-message packet.
REQ-037 cnt=3 with second message carrying msg_sop -> 7 beats, out_error=1 only on final beat; next packet out_error=0.
REQ-038 seq_num forced via SEQ_INIT=32'hFFFF_FFFF, one packet -> header seq FFFF_FFFF, seq_num then 0.
REQ-039 Reset asserted during MSG_HI of cnt=4 packet -> out_valid=0 immediately, no eop, next packet header seq=SEQ_INIT.
